// File: rtl/qar_timer_pkg.sv
// Shared definitions for the timer/watchdog/capture/PWM bus peripheral:
// register word indices (byte offset >> 2), CTRL/STATUS bit positions,
// the default watchdog kick key and the bus handshake state type.
package qar_timer_pkg;

  localparam logic [3:0] REG_CTRL       = 4'h0;
  localparam logic [3:0] REG_STATUS     = 4'h1;
  localparam logic [3:0] REG_TMR_LOAD   = 4'h2;
  localparam logic [3:0] REG_TMR_COUNT  = 4'h3;
  localparam logic [3:0] REG_PRESCALE   = 4'h4;
  localparam logic [3:0] REG_WDT_LOAD   = 4'h5;
  localparam logic [3:0] REG_WDT_KICK   = 4'h6;
  localparam logic [3:0] REG_CAPTURE    = 4'h7;
  localparam logic [3:0] REG_PWM_PERIOD = 4'h8;
  localparam logic [3:0] REG_PWM_DUTY   = 4'h9;

  localparam int CTRL_TMR_EN      = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_WDT_EN      = 2;
  localparam int CTRL_CAP_EN      = 3;
  localparam int CTRL_PWM_EN      = 4;
  localparam int CTRL_TMR_IRQ_EN  = 5;

  localparam int STAT_TMR_EXPIRED = 0;
  localparam int STAT_CAP_VALID   = 1;
  localparam int STAT_WDT_EXPIRED = 2;
  localparam int STAT_PWM_LEVEL   = 3;

  localparam logic [31:0] WDT_KEY_DEFAULT = 32'h5A5A_0001;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/qar_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module qar_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Resynchronise the pin and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise_pulse = sync & ~sync_d;

endmodule

// File: rtl/qar_timer_bus_slave.sv
// Memory-mapped timer / watchdog / input capture / PWM peripheral.
// Bus handshake: request sampled in IDLE, one-cycle mem_ready in ACK,
// writes land on the ACK->IDLE edge.
// Optional build macro QAR_TIMER_WDT_LOCK_EN: once the watchdog is enabled,
// CTRL.wdt_en and WDT_LOAD become write-protected until reset.
module qar_timer_bus_slave
  import qar_timer_pkg::*;
#(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] WDT_KEY    = WDT_KEY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        capture_in,
  output logic        pwm_out,
  output logic        irq_timer,
  output logic        wdt_reset_req
);

  bus_state_t state, state_next;
  logic        req_we;
  logic [3:0]  req_idx;
  logic [31:0] req_wdata;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic wr_en, wr_ctrl, wr_status, wr_tmr_load, wr_prescale;
  logic wr_wdt_load, wr_wdt_kick, wr_pwm_period, wr_pwm_duty;

  logic tmr_en, auto_reload, wdt_en, cap_en, pwm_en, tmr_irq_en;
  logic tmr_expired, cap_valid, wdt_expired;

  logic [31:0]           tmr_load, tmr_count, wdt_load, wdt_count, capture;
  logic [31:0]           pwm_period, pwm_duty, pwm_cnt;
  logic [PRESCALE_W-1:0] prescale, presc_cnt;
  logic                  pwm_q;

  logic tmr_tick, tmr_wrap, wdt_lock, wdt_start;
  logic wdt_kick_ok, wdt_kick_bad, wdt_expire_set;
  logic cap_rise, cap_set;
  logic unused_addr;

  assign unused_addr = ^{mem_addr[31:6], mem_addr[1:0]};

  // Write strobes fire on the ACK->IDLE edge of a captured write request
  assign wr_en         = (state == ACK) && req_we;
  assign wr_ctrl       = wr_en && (req_idx == REG_CTRL);
  assign wr_status     = wr_en && (req_idx == REG_STATUS);
  assign wr_tmr_load   = wr_en && (req_idx == REG_TMR_LOAD);
  assign wr_prescale   = wr_en && (req_idx == REG_PRESCALE);
  assign wr_wdt_load   = wr_en && (req_idx == REG_WDT_LOAD) && !wdt_lock;
  assign wr_wdt_kick   = wr_en && (req_idx == REG_WDT_KICK);
  assign wr_pwm_period = wr_en && (req_idx == REG_PWM_PERIOD);
  assign wr_pwm_duty   = wr_en && (req_idx == REG_PWM_DUTY);

  // Bus handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Accept in IDLE, acknowledge for exactly one cycle, ignore valid in ACK
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_valid) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_ready = (state == ACK);
  assign mem_rdata = rdata_q;

  // Read multiplexer on the live address; its value is registered at accept
  always_comb begin
    rd_mux = 32'h0;
    case (mem_addr[5:2])
      REG_CTRL: begin
        rd_mux[CTRL_TMR_EN]      = tmr_en;
        rd_mux[CTRL_AUTO_RELOAD] = auto_reload;
        rd_mux[CTRL_WDT_EN]      = wdt_en;
        rd_mux[CTRL_CAP_EN]      = cap_en;
        rd_mux[CTRL_PWM_EN]      = pwm_en;
        rd_mux[CTRL_TMR_IRQ_EN]  = tmr_irq_en;
      end
      REG_STATUS: begin
        rd_mux[STAT_TMR_EXPIRED] = tmr_expired;
        rd_mux[STAT_CAP_VALID]   = cap_valid;
        rd_mux[STAT_WDT_EXPIRED] = wdt_expired;
        rd_mux[STAT_PWM_LEVEL]   = pwm_q;
      end
      REG_TMR_LOAD:   rd_mux = tmr_load;
      REG_TMR_COUNT:  rd_mux = tmr_count;
      REG_PRESCALE:   rd_mux = 32'(prescale);
      REG_WDT_LOAD:   rd_mux = wdt_load;
      REG_CAPTURE:    rd_mux = capture;
      REG_PWM_PERIOD: rd_mux = pwm_period;
      REG_PWM_DUTY:   rd_mux = pwm_duty;
      default:        rd_mux = 32'h0;
    endcase
  end

  // Capture the request on accept; read data is only non-zero during ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_idx   <= 4'h0;
      req_wdata <= 32'h0;
      rdata_q   <= 32'h0;
    end else if ((state == IDLE) && mem_valid) begin
      req_we    <= mem_we;
      req_idx   <= mem_addr[5:2];
      req_wdata <= mem_wdata;
      rdata_q   <= mem_we ? 32'h0 : rd_mux;
    end else if (state == ACK) begin
      rdata_q   <= 32'h0;
    end
  end

`ifdef QAR_TIMER_WDT_LOCK_EN
  // The first write that enables the watchdog locks its configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wdt_lock <= 1'b0;
    else if (wr_ctrl && req_wdata[CTRL_WDT_EN]) wdt_lock <= 1'b1;
  end
`else
  assign wdt_lock = 1'b0;
`endif

  assign tmr_tick  = tmr_en && (presc_cnt == prescale);
  assign tmr_wrap  = tmr_tick && (tmr_count == 32'd0) && !wr_tmr_load;
  assign wdt_start = wr_ctrl && !wdt_lock && req_wdata[CTRL_WDT_EN] && !wdt_en;

  // Control bits; a one-shot timer drops tmr_en itself when it expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_en      <= 1'b0;
      auto_reload <= 1'b0;
      wdt_en      <= 1'b0;
      cap_en      <= 1'b0;
      pwm_en      <= 1'b0;
      tmr_irq_en  <= 1'b0;
    end else if (wr_ctrl) begin
      tmr_en      <= req_wdata[CTRL_TMR_EN];
      auto_reload <= req_wdata[CTRL_AUTO_RELOAD];
      cap_en      <= req_wdata[CTRL_CAP_EN];
      pwm_en      <= req_wdata[CTRL_PWM_EN];
      tmr_irq_en  <= req_wdata[CTRL_TMR_IRQ_EN];
      if (!wdt_lock) wdt_en <= req_wdata[CTRL_WDT_EN];
    end else if (tmr_wrap && !auto_reload) begin
      tmr_en      <= 1'b0;
    end
  end

  // Prescale register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           prescale <= '0;
    else if (wr_prescale) prescale <= req_wdata[PRESCALE_W-1:0];
  end

  // Prescaler and down-counter; a LOAD write restarts both from scratch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_load  <= 32'h0;
      tmr_count <= 32'h0;
      presc_cnt <= '0;
    end else if (wr_tmr_load) begin
      tmr_load  <= req_wdata;
      tmr_count <= req_wdata;
      presc_cnt <= '0;
    end else if (tmr_tick) begin
      presc_cnt <= '0;
      if (tmr_count != 32'd0) tmr_count <= tmr_count - 32'd1;
      else if (auto_reload)   tmr_count <= tmr_load;
    end else if (tmr_en) begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign wdt_kick_ok    = wr_wdt_kick && (req_wdata == WDT_KEY);
  assign wdt_kick_bad   = wr_wdt_kick && (req_wdata != WDT_KEY);
  assign wdt_expire_set = (wdt_en && (wdt_count <= 32'd1) && !wdt_kick_ok) || wdt_kick_bad;

  // Watchdog reload value, all ones out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           wdt_load <= 32'hFFFF_FFFF;
    else if (wr_wdt_load) wdt_load <= req_wdata;
  end

  // Watchdog counter: reload on enable or valid kick, stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wdt_count <= 32'h0;
    else if (wdt_start || wdt_kick_ok)           wdt_count <= wdt_load;
    else if (wdt_en && (wdt_count != 32'd0))     wdt_count <= wdt_count - 32'd1;
  end

  assign cap_set = cap_en && cap_rise;

  qar_sync_edge u_cap_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (capture_in),
    .rise_pulse (cap_rise)
  );

  // Snapshot the timer count on each synchronised capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       capture <= 32'h0;
    else if (cap_set) capture <= tmr_count;
  end

  // Sticky status flags: write-one-to-clear, hardware set wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_expired <= 1'b0;
      cap_valid   <= 1'b0;
      wdt_expired <= 1'b0;
    end else begin
      tmr_expired <= (tmr_expired & ~(wr_status & req_wdata[STAT_TMR_EXPIRED])) | tmr_wrap;
      cap_valid   <= (cap_valid   & ~(wr_status & req_wdata[STAT_CAP_VALID]))   | cap_set;
      wdt_expired <= (wdt_expired & ~(wr_status & req_wdata[STAT_WDT_EXPIRED])) | wdt_expire_set;
    end
  end

  // PWM period and duty registers; a period write restarts the cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_period <= 32'h0;
      pwm_duty   <= 32'h0;
    end else begin
      if (wr_pwm_period) pwm_period <= req_wdata;
      if (wr_pwm_duty)   pwm_duty   <= req_wdata;
    end
  end

  // PWM phase counter, parked at zero when disabled or period is zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      pwm_cnt <= 32'h0;
    else if (wr_pwm_period || !pwm_en)               pwm_cnt <= 32'h0;
    else if (pwm_period == 32'd0)                    pwm_cnt <= 32'h0;
    else if (pwm_cnt >= pwm_period - 32'd1)          pwm_cnt <= 32'h0;
    else                                             pwm_cnt <= pwm_cnt + 32'd1;
  end

  // Registered PWM pin; duty >= period naturally yields a constant high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= pwm_en && (pwm_period != 32'd0) && (pwm_cnt < pwm_duty);
  end

  assign pwm_out       = pwm_q;
  assign irq_timer     = tmr_expired & tmr_irq_en;
  assign wdt_reset_req = wdt_expired;

endmodule
